fifo_prog_flags: RTL and testbench
==================================

Name: fifo_prog_flags

Overview:
Parametrised synchronous FIFO; next generation of the team's fifo_memory block.
Adds programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags.
Adds a selectable first-word-fall-through (FWFT) read mode and defined simultaneous read/write behaviour.
Sits between a producer and consumer in one clock domain; storage array is a separate sub-module.

Parameters:
DATA_WIDTH, 8, width of each entry in bits
ADDR_WIDTH, 5, log2 of depth; DEPTH = 2**ADDR_WIDTH
FWFT, 0, 0 = standard registered read (1-cycle latency), 1 = first-word-fall-through
AF_THRESH, DEPTH-4, almost_full asserted when count >= AF_THRESH
AE_THRESH, 4, almost_empty asserted when count <= AE_THRESH

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous, active-high reset
write_enable  in  1  push request
write_data  in  DATA_WIDTH  data to push
read_enable  in  1  pop request
read_data  out  DATA_WIDTH  popped data (standard mode) / head of FIFO (FWFT mode)
read_valid  out  1  standard mode: read_data updated this cycle; FWFT mode: equals ~empty
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clear_errors  in  1  clears overflow/underflow next edge

Behaviour:
- Reset (rst=1 at posedge) clears wr_ptr, rd_ptr, count, overflow, underflow, read_valid, and read_data to 0.
- During reset, empty=1, full=0, almost_empty=1; almost_full = (AF_THRESH==0). Memory contents are not cleared.
- Reset has priority over all other inputs. Reset mid-operation discards all entries; the first write after reset lands at address 0.
- Pointers are ADDR_WIDTH+1 bits, wrapping modulo 2*DEPTH; the RAM is addressed by the low ADDR_WIDTH bits.
- full/empty/almost_* are combinational from the registered count (no extra latency vs count).
- Write accept: wr_acc = write_enable & ~full. An accepted write stores write_data at wr_ptr and increments wr_ptr.
- Full rule: a write while full is rejected, even if a read is accepted the same cycle. It sets overflow; contents are unchanged.
- Read accept: rd_acc = read_enable & ~empty; an accepted read increments rd_ptr.
- Empty rule: a read while empty is rejected, even if a write is accepted the same cycle. It sets underflow.
- count next = count + wr_acc - rd_acc. A simultaneous accepted read and write leaves count unchanged.
- Standard mode (FWFT=0): on rd_acc, read_data <= mem[rd_ptr] at that edge and read_valid=1 for exactly that next cycle. Otherwise read_valid=0 and read_data holds its last value.
- FWFT mode (FWFT=1): read_data = mem[rd_ptr] combinationally and read_valid = ~empty. rd_acc advances to the next entry.
- FWFT write-to-visible latency: a write to an empty FIFO is visible on read_data the cycle after the write edge.
- Sticky flags: set on the offending cycle's edge and held until clear_errors=1.
- If clear_errors and a new error occur in the same cycle, the set wins.

Decomposition:
- Package fifo_pkg: function clog2-style depth helper, and typedef fifo_count_t sized ADDR_WIDTH+1 via a parametrised localparam helper.
- Sub-module fifo_ram: DEPTH x DATA_WIDTH array with synchronous write, plus one async read port (FWFT) or registered read port (standard), selected by parameter.
- Pointers, count, flags and error logic live in the top.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=5, DEPTH=32, AF_THRESH=28, AE_THRESH=4):
- Fill/drain, FWFT=0: write 0x00..0x1F.
  -> full=1, count=32, almost_full asserted at count 28.
  -> 32 reads return 0x00..0x1F in order, each with read_valid one cycle after read_enable; empty=1 at end.
- Overflow: at full, write 0xAA with read_enable=1 same cycle.
  -> read accepted, write rejected, count=31, overflow=1.
  -> overflow stays 1 until clear_errors pulse, then 0.
- Underflow: empty, assert read_enable with write 0x55 same cycle.
  -> write accepted, count=1, underflow=1, read_valid=0.
  -> the next read returns 0x55.
- Wrap-around: 50 write/read pairs interleaved (one entry occupancy).
  -> data matches in order across pointer wrap; count toggles 0/1; no error flags.
- FWFT=1: write 0x3C to empty FIFO.
  -> next cycle read_data=0x3C, read_valid=1.
  -> read_enable pops; empty=1 the following cycle.
- Reset mid-operation: with count=10, assert rst for one cycle.
  -> count=0, empty=1, flags 0, read_data=0.
  -> next write 0x11 then read returns 0x11.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the programmable-flag FIFO family.
package fifo_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 5;

    function automatic int depth_of(input int addr_width);
        return 32'sd1 <<< addr_width;
    endfunction

    // Smallest address width able to index 'depth' entries.
    function automatic int clog2_depth(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic int count_width(input int addr_width);
        return addr_width + 32'sd1;
    endfunction

    localparam int DEFAULT_COUNT_WIDTH = count_width(DEFAULT_ADDR_WIDTH);

    typedef logic [DEFAULT_COUNT_WIDTH-1:0] fifo_count_t;

endpackage

// File: rtl/fifo_prog_flags_if.sv
// Producer/consumer bus of fifo_prog_flags; master drives requests, slave is the FIFO.
interface fifo_prog_flags_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) ();

    logic                  write_enable;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  clear_errors;

    modport master (
        output write_enable, write_data, read_enable, clear_errors,
        input  read_data, read_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  write_enable, write_data, read_enable, clear_errors,
        output read_data, read_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// FIFO storage: synchronous write, read port either combinational (FWFT) or registered.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  DEPTH      = 32,
    parameter int  FWFT       = 0,
    localparam int AW         = clog2_depth(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Storage array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read data captures the head only when a pop is accepted.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Registered read port with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = (FWFT != 32'sd0) ? mem_q[raddr] : rdata_q;

endmodule

// File: rtl/fifo_prog_flags.sv
// Synchronous FIFO with programmable almost flags, occupancy count, sticky errors and FWFT option.
module fifo_prog_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = depth_of(ADDR_WIDTH) - 32'sd4,
    parameter int AE_THRESH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    fifo_prog_flags_if.slave  bus
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);
    localparam int CW    = count_width(ADDR_WIDTH);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);
    localparam cnt_t AF_LVL    = cnt_t'(AF_THRESH);
    localparam cnt_t AE_LVL    = cnt_t'(AE_THRESH);
    localparam cnt_t ONE       = cnt_t'(32'd1);

    cnt_t wr_ptr_q, wr_ptr_d;
    cnt_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;
    logic read_valid_q, read_valid_d;

    logic full, empty, almost_full, almost_empty;
    logic wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Status flags derive only from the registered count.
    always_comb begin
        full         = (count_q == DEPTH_CNT);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AF_LVL);
        almost_empty = (count_q <= AE_LVL);
    end

    // Accept rules: a full FIFO refuses writes and an empty one refuses reads,
    // regardless of what the opposite side does in the same cycle.
    always_comb begin
        wr_acc = bus.write_enable & ~full;
        rd_acc = bus.read_enable & ~empty;
    end

    // Pointer, occupancy and sticky-error next state; a new error beats clear_errors.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        read_valid_d = rd_acc;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        count_d = count_q + cnt_t'(wr_acc) - cnt_t'(rd_acc);

        if (bus.write_enable && full) begin
            overflow_d = 1'b1;
        end else if (bus.clear_errors) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (bus.read_enable && empty) begin
            underflow_d = 1'b1;
        end else if (bus.clear_errors) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Control state register; reset outranks every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            read_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            read_valid_q <= read_valid_d;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .FWFT       (FWFT)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc & ~rst),
        .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata (bus.write_data),
        .re    (rd_acc),
        .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata (ram_rdata)
    );

    assign bus.read_data    = ram_rdata;
    assign bus.read_valid   = (FWFT != 32'sd0) ? ~empty : read_valid_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = almost_full;
    assign bus.almost_empty = almost_empty;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_prog_flags.sv
// Directed bench for fifo_prog_flags: standard-read instance plus an FWFT instance.
module tb_fifo_prog_flags;
    import fifo_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    fifo_prog_flags_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) s_if ();
    fifo_prog_flags_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) f_if ();

    fifo_prog_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .FWFT(0), .AF_THRESH(28), .AE_THRESH(4))
        u_std (.clk(clk), .rst(rst), .bus(s_if.slave));

    fifo_prog_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .FWFT(1), .AF_THRESH(28), .AE_THRESH(4))
        u_fwft (.clk(clk), .rst(rst), .bus(f_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if (s_if.count !== 6'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", s_if.count); end
        vectors++; if (s_if.empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", s_if.empty); end
        vectors++; if (s_if.full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", s_if.full); end
        vectors++; if (s_if.almost_empty !== 1'b1) begin miscompares++; $display("FAIL reset_ae got %b want 1", s_if.almost_empty); end
        vectors++; if (s_if.almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_af got %b want 0", s_if.almost_full); end
        vectors++; if ({s_if.overflow, s_if.underflow} !== 2'b00) begin miscompares++; $display("FAIL reset_errs got %b%b want 00", s_if.overflow, s_if.underflow); end
        vectors++; if (s_if.read_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid got %b want 0", s_if.read_valid); end
        vectors++; if (s_if.read_data !== 8'h00) begin miscompares++; $display("FAIL reset_rdata got %h want 00", s_if.read_data); end
        vectors++; if (f_if.read_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fwft_rvalid got %b want 0", f_if.read_valid); end
    endtask

    task automatic test_fill_drain();
        fifo_count_t exp_cnt;
        for (int i = 0; i < 32; i++) begin
            s_if.write_enable = 1'b1;
            s_if.write_data   = 8'(i);
            tick();
            exp_cnt = fifo_count_t'(i + 1);
            vectors++; if (s_if.count !== exp_cnt) begin miscompares++; $display("FAIL fill_count[%0d] got %0d want %0d", i, s_if.count, exp_cnt); end
            vectors++; if (s_if.almost_full !== (i + 1 >= 28)) begin miscompares++; $display("FAIL fill_af[%0d] got %b want %b", i, s_if.almost_full, (i + 1 >= 28)); end
            vectors++; if (s_if.almost_empty !== (i + 1 <= 4)) begin miscompares++; $display("FAIL fill_ae[%0d] got %b want %b", i, s_if.almost_empty, (i + 1 <= 4)); end
        end
        s_if.write_enable = 1'b0;
        vectors++; if (s_if.full !== 1'b1) begin miscompares++; $display("FAIL fill_full got %b want 1", s_if.full); end
        for (int i = 0; i < 32; i++) begin
            s_if.read_enable = 1'b1;
            tick();
            exp_cnt = fifo_count_t'(31 - i);
            vectors++; if (s_if.read_valid !== 1'b1) begin miscompares++; $display("FAIL drain_rvalid[%0d] got %b want 1", i, s_if.read_valid); end
            vectors++; if (s_if.read_data !== 8'(i)) begin miscompares++; $display("FAIL drain_data[%0d] got %h want %h", i, s_if.read_data, 8'(i)); end
            vectors++; if (s_if.count !== exp_cnt) begin miscompares++; $display("FAIL drain_count[%0d] got %0d want %0d", i, s_if.count, exp_cnt); end
        end
        s_if.read_enable = 1'b0;
        tick();
        vectors++; if (s_if.read_valid !== 1'b0) begin miscompares++; $display("FAIL drain_idle_rvalid got %b want 0", s_if.read_valid); end
        vectors++; if (s_if.read_data !== 8'h1F) begin miscompares++; $display("FAIL drain_hold_data got %h want 1f", s_if.read_data); end
        vectors++; if (s_if.empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty got %b want 1", s_if.empty); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 32; i++) begin
            s_if.write_enable = 1'b1;
            s_if.write_data   = 8'(8'h40 + i);
            tick();
        end
        s_if.write_data  = 8'hAA;
        s_if.read_enable = 1'b1;
        tick();
        s_if.write_enable = 1'b0;
        s_if.read_enable  = 1'b0;
        vectors++; if (s_if.count !== 6'd31) begin miscompares++; $display("FAIL ovf_count got %0d want 31", s_if.count); end
        vectors++; if (s_if.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b want 1", s_if.overflow); end
        vectors++; if (s_if.read_data !== 8'h40) begin miscompares++; $display("FAIL ovf_rdata got %h want 40", s_if.read_data); end
        tick();
        tick();
        vectors++; if (s_if.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b want 1", s_if.overflow); end
        s_if.clear_errors = 1'b1;
        tick();
        s_if.clear_errors = 1'b0;
        vectors++; if (s_if.overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got %b want 0", s_if.overflow); end
        for (int i = 1; i < 32; i++) begin
            s_if.read_enable = 1'b1;
            tick();
            vectors++; if (s_if.read_data !== 8'(8'h40 + i)) begin miscompares++; $display("FAIL ovf_drain[%0d] got %h want %h", i, s_if.read_data, 8'(8'h40 + i)); end
        end
        s_if.read_enable = 1'b0;
        vectors++; if (s_if.empty !== 1'b1) begin miscompares++; $display("FAIL ovf_end_empty got %b want 1", s_if.empty); end
    endtask

    task automatic test_underflow();
        s_if.read_enable  = 1'b1;
        s_if.write_enable = 1'b1;
        s_if.write_data   = 8'h55;
        tick();
        s_if.write_enable = 1'b0;
        s_if.read_enable  = 1'b0;
        vectors++; if (s_if.count !== 6'd1) begin miscompares++; $display("FAIL udf_count got %0d want 1", s_if.count); end
        vectors++; if (s_if.underflow !== 1'b1) begin miscompares++; $display("FAIL udf_flag got %b want 1", s_if.underflow); end
        vectors++; if (s_if.read_valid !== 1'b0) begin miscompares++; $display("FAIL udf_rvalid got %b want 0", s_if.read_valid); end
        s_if.read_enable = 1'b1;
        tick();
        vectors++; if (s_if.read_data !== 8'h55) begin miscompares++; $display("FAIL udf_rdata got %h want 55", s_if.read_data); end
        vectors++; if (s_if.read_valid !== 1'b1) begin miscompares++; $display("FAIL udf_rvalid2 got %b want 1", s_if.read_valid); end
        s_if.clear_errors = 1'b1;
        tick();
        s_if.read_enable = 1'b0;
        vectors++; if (s_if.underflow !== 1'b1) begin miscompares++; $display("FAIL udf_set_wins got %b want 1", s_if.underflow); end
        tick();
        s_if.clear_errors = 1'b0;
        vectors++; if (s_if.underflow !== 1'b0) begin miscompares++; $display("FAIL udf_clear got %b want 0", s_if.underflow); end
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        for (int i = 0; i < 50; i++) begin
            d = 8'(i * 7 + 3);
            s_if.write_enable = 1'b1;
            s_if.write_data   = d;
            tick();
            s_if.write_enable = 1'b0;
            vectors++; if (s_if.count !== 6'd1) begin miscompares++; $display("FAIL wrap_count1[%0d] got %0d want 1", i, s_if.count); end
            s_if.read_enable = 1'b1;
            tick();
            s_if.read_enable = 1'b0;
            vectors++; if (s_if.read_data !== d) begin miscompares++; $display("FAIL wrap_data[%0d] got %h want %h", i, s_if.read_data, d); end
            vectors++; if (s_if.count !== 6'd0) begin miscompares++; $display("FAIL wrap_count0[%0d] got %0d want 0", i, s_if.count); end
        end
        vectors++; if ({s_if.overflow, s_if.underflow} !== 2'b00) begin miscompares++; $display("FAIL wrap_errs got %b%b want 00", s_if.overflow, s_if.underflow); end
    endtask

    task automatic test_fwft();
        f_if.write_enable = 1'b1;
        f_if.write_data   = 8'h3C;
        tick();
        f_if.write_enable = 1'b0;
        vectors++; if (f_if.read_data !== 8'h3C) begin miscompares++; $display("FAIL fwft_head got %h want 3c", f_if.read_data); end
        vectors++; if (f_if.read_valid !== 1'b1) begin miscompares++; $display("FAIL fwft_rvalid got %b want 1", f_if.read_valid); end
        f_if.read_enable = 1'b1;
        tick();
        f_if.read_enable = 1'b0;
        vectors++; if (f_if.empty !== 1'b1) begin miscompares++; $display("FAIL fwft_empty got %b want 1", f_if.empty); end
        vectors++; if (f_if.read_valid !== 1'b0) begin miscompares++; $display("FAIL fwft_rvalid_off got %b want 0", f_if.read_valid); end
        f_if.write_enable = 1'b1;
        f_if.write_data   = 8'hA1;
        tick();
        f_if.write_data   = 8'hA2;
        tick();
        f_if.write_enable = 1'b0;
        vectors++; if (f_if.read_data !== 8'hA1) begin miscompares++; $display("FAIL fwft_head1 got %h want a1", f_if.read_data); end
        f_if.read_enable = 1'b1;
        tick();
        vectors++; if (f_if.read_data !== 8'hA2) begin miscompares++; $display("FAIL fwft_head2 got %h want a2", f_if.read_data); end
        vectors++; if (f_if.count !== 6'd1) begin miscompares++; $display("FAIL fwft_count got %0d want 1", f_if.count); end
        tick();
        f_if.read_enable = 1'b0;
        vectors++; if (f_if.empty !== 1'b1) begin miscompares++; $display("FAIL fwft_empty2 got %b want 1", f_if.empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) begin
            s_if.write_enable = 1'b1;
            s_if.write_data   = 8'(8'hC0 + i);
            tick();
        end
        vectors++; if (s_if.count !== 6'd10) begin miscompares++; $display("FAIL rstmid_pre_count got %0d want 10", s_if.count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s_if.write_enable = 1'b0;
        vectors++; if (s_if.count !== 6'd0) begin miscompares++; $display("FAIL rstmid_count got %0d want 0", s_if.count); end
        vectors++; if (s_if.empty !== 1'b1) begin miscompares++; $display("FAIL rstmid_empty got %b want 1", s_if.empty); end
        vectors++; if ({s_if.overflow, s_if.underflow, s_if.read_valid} !== 3'b000) begin miscompares++; $display("FAIL rstmid_flags got %b%b%b want 000", s_if.overflow, s_if.underflow, s_if.read_valid); end
        vectors++; if (s_if.read_data !== 8'h00) begin miscompares++; $display("FAIL rstmid_rdata got %h want 00", s_if.read_data); end
        s_if.write_enable = 1'b1;
        s_if.write_data   = 8'h11;
        tick();
        s_if.write_enable = 1'b0;
        s_if.read_enable  = 1'b1;
        tick();
        s_if.read_enable  = 1'b0;
        vectors++; if (s_if.read_data !== 8'h11) begin miscompares++; $display("FAIL rstmid_first got %h want 11", s_if.read_data); end
        vectors++; if (s_if.empty !== 1'b1) begin miscompares++; $display("FAIL rstmid_end_empty got %b want 1", s_if.empty); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        s_if.write_enable = 1'b0; s_if.write_data = 8'h00; s_if.read_enable = 1'b0; s_if.clear_errors = 1'b0;
        f_if.write_enable = 1'b0; f_if.write_data = 8'h00; f_if.read_enable = 1'b0; f_if.clear_errors = 1'b0;
        tick();
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_wrap();
        test_fwft();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
